// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port plus the
// {instr, pc, pc+4} valid/ready stream towards the core.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
    output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding word read
// at a time and buffers returned words in a small circular queue.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   stale_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic          push;
  logic          pop;
  logic          has_space;
  logic [31:0]   redir_pc;

  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    pop       = (count_q != '0) && bus.out_ready;
    push      = (state_q == ST_WAIT) && bus.imem_ack;
    count_d   = count_q + CW'(push) - CW'(pop);
    has_space = count_d < DEPTH_C;
  end

  assign bus.imem_req     = (state_q != ST_IDLE);
  assign bus.imem_addr    = (state_q == ST_DISCARD) ? stale_q : fetch_pc_q;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_instr    = instr_q[head_q];
  assign bus.out_pc       = pc_q[head_q];
  assign bus.out_pc_plus4 = pc_q[head_q] + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      stale_q    <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (bus.redirect) begin
      // Redirect wins over push/pop; an unacked read must still be drained at its old address.
      fetch_pc_q <= redir_pc;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      if (state_q == ST_WAIT && !bus.imem_ack) begin
        state_q <= ST_DISCARD;
        stale_q <= fetch_pc_q;
      end else if (state_q == ST_DISCARD && !bus.imem_ack) begin
        state_q <= ST_DISCARD;
      end else begin
        state_q <= ST_WAIT;
      end
    end else begin
      count_q <= count_d;
      if (pop) head_q <= head_q + PW'(1);
      if (push) begin
        instr_q[tail_q] <= bus.imem_rdata;
        pc_q[tail_q]    <= fetch_pc_q;
        tail_q          <= tail_q + PW'(1);
        fetch_pc_q      <= fetch_pc_q + 32'd4;
      end
      case (state_q)
        ST_IDLE:    if (has_space) state_q <= ST_WAIT;
        ST_WAIT:    if (bus.imem_ack && !has_space) state_q <= ST_IDLE;
        ST_DISCARD: if (bus.imem_ack) state_q <= ST_WAIT;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end
endmodule
